// File: rtl/noc_crossbar_switch_inner.sv
// 5x5 NoC crossbar datapath: per-input demux, per-output mux, registered outputs.
// An output receives an input's flit only when the two selects name each other.
module noc_crossbar_switch_inner #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] n_cs_i,
    input  logic [DATA_WIDTH-1:0] s_cs_i,
    input  logic [DATA_WIDTH-1:0] w_cs_i,
    input  logic [DATA_WIDTH-1:0] e_cs_i,
    input  logic [DATA_WIDTH-1:0] l_cs_i,
    input  logic [2:0]            n_cs_sel_demux_i,
    input  logic [2:0]            s_cs_sel_demux_i,
    input  logic [2:0]            w_cs_sel_demux_i,
    input  logic [2:0]            e_cs_sel_demux_i,
    input  logic [2:0]            l_cs_sel_demux_i,
    input  logic [2:0]            n_cs_sel_mux_i,
    input  logic [2:0]            s_cs_sel_mux_i,
    input  logic [2:0]            w_cs_sel_mux_i,
    input  logic [2:0]            e_cs_sel_mux_i,
    input  logic [2:0]            l_cs_sel_mux_i,
    output logic [DATA_WIDTH-1:0] n_cs_o,
    output logic [DATA_WIDTH-1:0] s_cs_o,
    output logic [DATA_WIDTH-1:0] w_cs_o,
    output logic [DATA_WIDTH-1:0] e_cs_o,
    output logic [DATA_WIDTH-1:0] l_cs_o
);

    localparam int NUM_PORTS = 5;

    logic [DATA_WIDTH-1:0] in_data   [NUM_PORTS];
    logic [2:0]            demux_sel [NUM_PORTS];
    logic [2:0]            mux_sel   [NUM_PORTS];
    logic [DATA_WIDTH-1:0] lane      [NUM_PORTS][NUM_PORTS];
    logic [DATA_WIDTH-1:0] next_out  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] out_q     [NUM_PORTS];

    // Port index order matches the direction encoding: N, S, W, E, L.
    assign in_data[0] = n_cs_i;
    assign in_data[1] = s_cs_i;
    assign in_data[2] = w_cs_i;
    assign in_data[3] = e_cs_i;
    assign in_data[4] = l_cs_i;

    assign demux_sel[0] = n_cs_sel_demux_i;
    assign demux_sel[1] = s_cs_sel_demux_i;
    assign demux_sel[2] = w_cs_sel_demux_i;
    assign demux_sel[3] = e_cs_sel_demux_i;
    assign demux_sel[4] = l_cs_sel_demux_i;

    assign mux_sel[0] = n_cs_sel_mux_i;
    assign mux_sel[1] = s_cs_sel_mux_i;
    assign mux_sel[2] = w_cs_sel_mux_i;
    assign mux_sel[3] = e_cs_sel_mux_i;
    assign mux_sel[4] = l_cs_sel_mux_i;

    // Invalid codes (5..7) never match a lane index, so they yield zero.
    always_comb begin
        for (int x = 0; x < NUM_PORTS; x++) begin
            for (int d = 0; d < NUM_PORTS; d++) begin
                lane[x][d] = '0;
                if (demux_sel[x] == 3'(d)) begin
                    lane[x][d] = in_data[x];
                end
            end
        end
        for (int d = 0; d < NUM_PORTS; d++) begin
            next_out[d] = '0;
            for (int s = 0; s < NUM_PORTS; s++) begin
                if (mux_sel[d] == 3'(s)) begin
                    next_out[d] = lane[s][d];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int d = 0; d < NUM_PORTS; d++) begin
                out_q[d] <= '0;
            end
        end else begin
            for (int d = 0; d < NUM_PORTS; d++) begin
                out_q[d] <= next_out[d];
            end
        end
    end

    assign n_cs_o = out_q[0];
    assign s_cs_o = out_q[1];
    assign w_cs_o = out_q[2];
    assign e_cs_o = out_q[3];
    assign l_cs_o = out_q[4];

endmodule

// File: tb/tb_noc_crossbar_switch_inner.sv
// Bench for noc_crossbar_switch_inner: directed routing cases with literal
// expectations plus randomized traffic against a per-cycle reference model.
module tb_noc_crossbar_switch_inner;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din  [5];
    logic [2:0]   dsel [5];
    logic [2:0]   msel [5];
    logic [W-1:0] dout [5];
    logic [W-1:0] exp_out [5];
    logic         check_en = 1'b0;
    int           checks = 0;
    int           failures = 0;
    string        pname [5] = '{"n", "s", "w", "e", "l"};

    always #5 clk = ~clk;

    noc_crossbar_switch_inner #(.DATA_WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst),
        .n_cs_i(din[0]), .s_cs_i(din[1]), .w_cs_i(din[2]), .e_cs_i(din[3]), .l_cs_i(din[4]),
        .n_cs_sel_demux_i(dsel[0]), .s_cs_sel_demux_i(dsel[1]), .w_cs_sel_demux_i(dsel[2]),
        .e_cs_sel_demux_i(dsel[3]), .l_cs_sel_demux_i(dsel[4]),
        .n_cs_sel_mux_i(msel[0]), .s_cs_sel_mux_i(msel[1]), .w_cs_sel_mux_i(msel[2]),
        .e_cs_sel_mux_i(msel[3]), .l_cs_sel_mux_i(msel[4]),
        .n_cs_o(dout[0]), .s_cs_o(dout[1]), .w_cs_o(dout[2]), .e_cs_o(dout[3]), .l_cs_o(dout[4])
    );

    // Reference: output D gets input S only if D's mux names S and S's demux names D.
    function automatic logic [W-1:0] route(int d);
        int s;
        s = int'(msel[d]);
        if (s < 5 && int'(dsel[s]) == d) return din[s];
        return '0;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 5; d++) exp_out[d] = rst ? '0 : route(d);
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            for (int d = 0; d < 5; d++) chk({"model_", pname[d]}, dout[d], exp_out[d]);
        end
    end

    task automatic set_cfg(input logic [14:0] dm, input logic [14:0] mx);
        for (int i = 0; i < 5; i++) begin
            dsel[i] = dm[14 - 3*i -: 3];
            msel[i] = mx[14 - 3*i -: 3];
        end
    endtask

    task automatic step_and_expect(input string name, input logic [W-1:0] e0, input logic [W-1:0] e1,
                                   input logic [W-1:0] e2, input logic [W-1:0] e3, input logic [W-1:0] e4);
        logic [W-1:0] req [5];
        req = '{e0, e1, e2, e3, e4};
        @(posedge clk);
        #1;
        for (int d = 0; d < 5; d++) chk({name, "_", pname[d]}, dout[d], req[d]);
        @(negedge clk);
    endtask

    initial begin
        din = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010};
        // Full permutation config, loaded while reset is held.
        set_cfg({3'd4, 3'd0, 3'd1, 3'd2, 3'd3}, {3'd1, 3'd2, 3'd3, 3'd4, 3'd0});
        #1;
        for (int d = 0; d < 5; d++) chk("reset_initial", dout[d], '0);
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 5; d++) chk("reset_held", dout[d], '0);
        @(negedge clk);
        rst = 1'b0;
        check_en = 1'b1;

        // Full permutation; first capture one edge after release.
        step_and_expect("perm", 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0001);

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 5; d++) chk("reset_async", dout[d], '0);
        @(negedge clk);
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 5; d++) chk("reset_hold", dout[d], '0);
        @(negedge clk);
        rst = 1'b0;
        step_and_expect("reset_release", 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0001);

        set_cfg({3'd4, 3'd0, 3'd0, 3'd0, 3'd0}, {3'd4, 3'd0, 3'd1, 3'd2, 3'd0});
        step_and_expect("partial", 16'h0010, 16'h0000, 16'h0000, 16'h0000, 16'h0001);

        set_cfg({3'd2, 3'd4, 3'd4, 3'd4, 3'd0}, {3'd4, 3'd0, 3'd0, 3'd0, 3'd0});
        step_and_expect("disagree", 16'h0010, 16'h0000, 16'h0001, 16'h0000, 16'h0000);

        // West's flit goes to Local, and Local's mux picks West, so that pair still matches.
        set_cfg({3'd4, 3'd4, 3'd4, 3'd4, 3'd0}, {3'd2, 3'd2, 3'd1, 3'd2, 3'd2});
        step_and_expect("fanin", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0004);

        set_cfg({3'd5, 3'd0, 3'd1, 3'd2, 3'd3}, {3'd1, 3'd2, 3'd3, 3'd7, 3'd0});
        step_and_expect("invalid", 16'h0002, 16'h0004, 16'h0008, 16'h0000, 16'h0000);

        set_cfg({3'd6, 3'd6, 3'd6, 3'd6, 3'd6}, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4});
        step_and_expect("invalid_all", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        set_cfg({3'd0, 3'd1, 3'd2, 3'd3, 3'd4}, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4});
        din = '{16'hA5A5, 16'h5A5A, 16'hFFFF, 16'h8001, 16'h1234};
        step_and_expect("loopback", 16'hA5A5, 16'h5A5A, 16'hFFFF, 16'h8001, 16'h1234);

        // Fan-out: every mux names North, only North's demux target (East) receives it.
        set_cfg({3'd3, 3'd5, 3'd5, 3'd5, 3'd5}, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0});
        step_and_expect("fanout", 16'h0000, 16'h0000, 16'h0000, 16'hA5A5, 16'h0000);

        // Random traffic; half the muxes are steered to agree with some demux.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 5; i++) begin
                din[i]  = W'($urandom);
                dsel[i] = 3'($urandom_range(0, 7));
            end
            for (int d = 0; d < 5; d++) begin
                msel[d] = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 1) == 1) begin
                    for (int s = 0; s < 5; s++) if (int'(dsel[s]) == d) msel[d] = 3'(s);
                end
            end
            if (c == 200) begin
                @(posedge clk);
                #3 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            @(negedge clk);
        end

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
